// File: rtl/action_merge_unit.sv
// Merges the per-sub-unit action results of one PHV into a single action word,
// buffers the result in a 2-entry FIFO and keeps saturating hit/miss/multi-hit statistics.
module action_merge_unit #(
    parameter int NUM_SUB_UNIT = 8,
    parameter int ACT_W        = 4160,
    parameter int PHV_LEN      = 2304,
    parameter int MERGE_MODE   = 0,
    parameter int CNT_W        = 32,
    parameter int IDX_W        = $clog2(NUM_SUB_UNIT)
) (
    input  logic                          axis_clk,
    input  logic                          aresetn,
    input  logic [PHV_LEN-1:0]            phv_in,
    input  logic                          phv_valid_in,
    input  logic [NUM_SUB_UNIT*ACT_W-1:0] action_in,
    input  logic [NUM_SUB_UNIT-1:0]       action_valid_in,
    output logic                          ready_out,
    output logic [PHV_LEN-1:0]            phv_out,
    output logic [ACT_W-1:0]              action_out,
    output logic [NUM_SUB_UNIT-1:0]       hit_mask_out,
    output logic [IDX_W-1:0]              hit_idx_out,
    output logic                          miss_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    input  logic                          cnt_clr,
    output logic [NUM_SUB_UNIT*CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0]              miss_cnt,
    output logic [CNT_W-1:0]              multi_cnt
);

    localparam int ENT_W = PHV_LEN + ACT_W + NUM_SUB_UNIT + IDX_W + 1;

    logic [ACT_W-1:0]  pri_act;
    logic [ACT_W-1:0]  or_act;
    logic [ACT_W-1:0]  merged_act;
    logic [IDX_W-1:0]  win_idx;
    logic              hit_any;
    logic              miss;
    logic              multi_hit;
    logic              accept;
    logic              pop;
    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [ENT_W-1:0]  in_ent;
    logic [ENT_W-1:0]  mem [2];
    logic [CNT_W-1:0]  hit_q [NUM_SUB_UNIT];
    logic [CNT_W-1:0]  miss_q;
    logic [CNT_W-1:0]  multi_q;

    // Scan units from index 0 upward: the first hit fixes priority action and index,
    // while every hit contributes to the OR-merged action.
    always_comb begin
        hit_any = 1'b0;
        win_idx = '0;
        pri_act = '0;
        or_act  = '0;
        for (int i = 0; i < NUM_SUB_UNIT; i++) begin
            if (action_valid_in[i]) begin
                or_act = or_act | action_in[i*ACT_W +: ACT_W];
                if (!hit_any) begin
                    hit_any = 1'b1;
                    win_idx = IDX_W'(i);
                    pri_act = action_in[i*ACT_W +: ACT_W];
                end
            end
        end
    end

    assign merged_act = (MERGE_MODE == 1) ? or_act : pri_act;
    assign miss       = ~hit_any;
    assign multi_hit  = |(action_valid_in & (action_valid_in - NUM_SUB_UNIT'(1)));

    assign ready_out = (count != 2'd2);
    assign valid_out = (count != 2'd0);
    assign accept    = phv_valid_in & ready_out;
    assign pop       = valid_out & ready_in;

    assign in_ent = {phv_in, merged_act, action_valid_in, win_idx, miss};

    // Two-slot ring buffer; with one entry held, a simultaneous push and pop
    // advances the read pointer onto the slot being written.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem[wr_ptr] <= in_ent;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign {phv_out, action_out, hit_mask_out, hit_idx_out, miss_out} = mem[rd_ptr];

    // Statistics move only on accepted PHVs; a clear wins over any increment.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_SUB_UNIT; i++) begin
                hit_q[i] <= '0;
            end
            miss_q  <= '0;
            multi_q <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < NUM_SUB_UNIT; i++) begin
                hit_q[i] <= '0;
            end
            miss_q  <= '0;
            multi_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_SUB_UNIT; i++) begin
                if (action_valid_in[i] && (hit_q[i] != '1)) begin
                    hit_q[i] <= hit_q[i] + CNT_W'(1);
                end
            end
            if (miss && (miss_q != '1)) begin
                miss_q <= miss_q + CNT_W'(1);
            end
            if (multi_hit && (multi_q != '1)) begin
                multi_q <= multi_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_SUB_UNIT; i++) begin
            hit_cnt[i*CNT_W +: CNT_W] = hit_q[i];
        end
    end

    assign miss_cnt  = miss_q;
    assign multi_cnt = multi_q;

endmodule

// File: tb/tb_action_merge_unit.sv
// Scoreboard bench for action_merge_unit: a priority-mode instance with 32-bit counters
// and an OR-mode instance with 2-bit counters share one stimulus stream.
module tb_action_merge_unit;

    localparam int NSU = 4;
    localparam int AW  = 16;
    localparam int PW  = 32;
    localparam int IW  = 2;

    typedef struct packed {
        logic [PW-1:0]  phv;
        logic [AW-1:0]  act_pri;
        logic [AW-1:0]  act_or;
        logic [NSU-1:0] mask;
        logic [IW-1:0]  idx;
        logic           miss;
    } exp_t;

    logic            axis_clk = 1'b0;
    logic            aresetn;
    logic [PW-1:0]   phv_in;
    logic            phv_valid_in;
    logic [NSU*AW-1:0] action_in;
    logic [NSU-1:0]  action_valid_in;
    logic            ready_in;
    logic            cnt_clr;

    logic              p_ready_out, p_miss_out, p_valid_out;
    logic [PW-1:0]     p_phv_out;
    logic [AW-1:0]     p_action_out;
    logic [NSU-1:0]    p_hit_mask_out;
    logic [IW-1:0]     p_hit_idx_out;
    logic [NSU*32-1:0] p_hit_cnt;
    logic [31:0]       p_miss_cnt, p_multi_cnt;

    logic              o_ready_out, o_miss_out, o_valid_out;
    logic [PW-1:0]     o_phv_out;
    logic [AW-1:0]     o_action_out;
    logic [NSU-1:0]    o_hit_mask_out;
    logic [IW-1:0]     o_hit_idx_out;
    logic [NSU*2-1:0]  o_hit_cnt;
    logic [1:0]        o_miss_cnt, o_multi_cnt;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 axis_clk = ~axis_clk;

    action_merge_unit #(.NUM_SUB_UNIT(NSU), .ACT_W(AW), .PHV_LEN(PW), .MERGE_MODE(0), .CNT_W(32)) dut_pri (
        .axis_clk(axis_clk), .aresetn(aresetn), .phv_in(phv_in), .phv_valid_in(phv_valid_in),
        .action_in(action_in), .action_valid_in(action_valid_in), .ready_out(p_ready_out),
        .phv_out(p_phv_out), .action_out(p_action_out), .hit_mask_out(p_hit_mask_out),
        .hit_idx_out(p_hit_idx_out), .miss_out(p_miss_out), .valid_out(p_valid_out),
        .ready_in(ready_in), .cnt_clr(cnt_clr), .hit_cnt(p_hit_cnt), .miss_cnt(p_miss_cnt),
        .multi_cnt(p_multi_cnt)
    );

    action_merge_unit #(.NUM_SUB_UNIT(NSU), .ACT_W(AW), .PHV_LEN(PW), .MERGE_MODE(1), .CNT_W(2)) dut_or (
        .axis_clk(axis_clk), .aresetn(aresetn), .phv_in(phv_in), .phv_valid_in(phv_valid_in),
        .action_in(action_in), .action_valid_in(action_valid_in), .ready_out(o_ready_out),
        .phv_out(o_phv_out), .action_out(o_action_out), .hit_mask_out(o_hit_mask_out),
        .hit_idx_out(o_hit_idx_out), .miss_out(o_miss_out), .valid_out(o_valid_out),
        .ready_in(ready_in), .cnt_clr(cnt_clr), .hit_cnt(o_hit_cnt), .miss_cnt(o_miss_cnt),
        .multi_cnt(o_multi_cnt)
    );

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // Drive one PHV, hold it until accepted, then queue its hand-computed result.
    task automatic apply_stimulus(input logic [PW-1:0] phv, input logic [NSU-1:0] vmask,
                                  input logic [NSU*AW-1:0] acts, input logic [AW-1:0] e_pri,
                                  input logic [AW-1:0] e_or, input logic [IW-1:0] e_idx,
                                  input logic e_miss);
        int waits = 0;
        exp_t e;
        phv_in          = phv;
        action_in       = acts;
        action_valid_in = vmask;
        phv_valid_in    = 1'b1;
        while (!p_ready_out && waits < 50) begin
            @(posedge axis_clk);
            #1;
            waits++;
        end
        if (!p_ready_out) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: ready_out stayed %b, expected 1 for phv %h", p_ready_out, phv);
            phv_valid_in = 1'b0;
            return;
        end
        @(posedge axis_clk);
        e.phv = phv; e.act_pri = e_pri; e.act_or = e_or; e.mask = vmask; e.idx = e_idx; e.miss = e_miss;
        exp_q.push_back(e);
        #1;
        phv_valid_in    = 1'b0;
        action_valid_in = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge axis_clk);
            n++;
        end
        #1;
        check_output("drain", 128'(exp_q.size()), 128'd0);
    endtask

    // Compare the presented head against the scoreboard front every cycle it is valid;
    // retire it only when the handshake completes.
    always @(negedge axis_clk) begin
        if (aresetn && p_valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_output: phv_out=%h action_out=%h, expected no output", p_phv_out, p_action_out);
            end else begin
                mon_e = exp_q[0];
                if (p_phv_out !== mon_e.phv || p_action_out !== mon_e.act_pri || p_hit_mask_out !== mon_e.mask ||
                    p_hit_idx_out !== mon_e.idx || p_miss_out !== mon_e.miss || o_valid_out !== 1'b1 ||
                    o_action_out !== mon_e.act_or) begin
                    errors++;
                    $display("[TB] FAIL output_entry: got phv=%h act=%h or_act=%h mask=%b idx=%0d miss=%b or_valid=%b, expected phv=%h act=%h or_act=%h mask=%b idx=%0d miss=%b",
                             p_phv_out, p_action_out, o_action_out, p_hit_mask_out, p_hit_idx_out, p_miss_out, o_valid_out,
                             mon_e.phv, mon_e.act_pri, mon_e.act_or, mon_e.mask, mon_e.idx, mon_e.miss);
                end
                if (ready_in) begin
                    mon_e = exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn = 1'b0; phv_in = '0; phv_valid_in = 1'b0; action_in = '0;
        action_valid_in = '0; ready_in = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(posedge axis_clk);
        #1;
        check_output("reset_valid", 128'(p_valid_out), 128'd0);
        check_output("reset_ready", 128'(p_ready_out), 128'd1);
        check_output("reset_outputs", 128'({p_phv_out, p_action_out, p_hit_mask_out, p_hit_idx_out, p_miss_out}), 128'd0);
        check_output("reset_counters", 128'({p_hit_cnt}), 128'd0);
        check_output("reset_miss_multi", 128'({p_miss_cnt, p_multi_cnt}), 128'd0);
        aresetn = 1'b1;
        @(posedge axis_clk);
        #1;

        $display("[TB] priority merge");
        apply_stimulus(32'hA0A0_0001, 4'b1010, 64'hDDDD_2222_1111_7777, 16'h1111, 16'hDDDD, 2'd1, 1'b0);
        check_output("multi_cnt_1", 128'(p_multi_cnt), 128'd1);
        check_output("hit_cnt_u1", 128'(p_hit_cnt[1*32 +: 32]), 128'd1);
        check_output("hit_cnt_u3", 128'(p_hit_cnt[3*32 +: 32]), 128'd1);
        check_output("hit_cnt_u0", 128'(p_hit_cnt[0 +: 32]), 128'd0);

        $display("[TB] or merge and miss");
        apply_stimulus(32'h0000_0002, 4'b0011, 64'h1234_FFFF_0F01_00F0, 16'h00F0, 16'h0FF1, 2'd0, 1'b0);
        apply_stimulus(32'h0000_0003, 4'b0000, 64'hAAAA_BBBB_CCCC_DDDD, 16'h0000, 16'h0000, 2'd0, 1'b1);
        check_output("miss_cnt", 128'(p_miss_cnt), 128'd1);
        check_output("hit_cnt_all", 128'(p_hit_cnt), {32'd1, 32'd0, 32'd2, 32'd1});
        check_output("multi_cnt_2", 128'(p_multi_cnt), 128'd2);
        check_output("or_hit_cnt_all", 128'(o_hit_cnt), 128'(8'b01_00_10_01));

        $display("[TB] hit flags without phv valid");
        action_in = 64'hFFFF_FFFF_FFFF_FFFF;
        action_valid_in = 4'hF;
        repeat (3) @(posedge axis_clk);
        #1;
        action_valid_in = '0;
        check_output("ignored_hit_cnt", 128'(p_hit_cnt), {32'd1, 32'd0, 32'd2, 32'd1});
        check_output("ignored_miss_multi", 128'({p_miss_cnt, p_multi_cnt}), {96'd0, 32'd1, 32'd2} >> 0);
        wait_drain();

        $display("[TB] backpressure");
        ready_in = 1'b0;
        apply_stimulus(32'h0000_000A, 4'b0001, 64'h0000_0000_0000_000A, 16'h000A, 16'h000A, 2'd0, 1'b0);
        apply_stimulus(32'h0000_000B, 4'b0100, 64'h0000_00B0_0000_0000, 16'h00B0, 16'h00B0, 2'd2, 1'b0);
        phv_in = 32'h0000_000C;
        action_in = 64'h0C00_0000_0000_0000;
        action_valid_in = 4'b1000;
        phv_valid_in = 1'b1;
        check_output("ready_out_full", 128'(p_ready_out), 128'd0);
        repeat (3) @(posedge axis_clk);
        #1;
        check_output("ready_out_stalled", 128'(p_ready_out), 128'd0);
        check_output("head_stalled", 128'(p_phv_out), 128'h0A);
        ready_in = 1'b1;
        apply_stimulus(32'h0000_000C, 4'b1000, 64'h0C00_0000_0000_0000, 16'h0C00, 16'h0C00, 2'd3, 1'b0);
        wait_drain();

        $display("[TB] counters");
        cnt_clr = 1'b1;
        @(posedge axis_clk);
        #1;
        cnt_clr = 1'b0;
        check_output("clr_counters", 128'(p_hit_cnt), 128'd0);
        check_output("clr_miss_multi", 128'({p_miss_cnt, p_multi_cnt}), 128'd0);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(32'h0000_0100 + 32'(k), 4'b0001, 64'h0000_0000_0000_5555, 16'h5555, 16'h5555, 2'd0, 1'b0);
        end
        check_output("sat_hit_cnt_u0", 128'(o_hit_cnt), 128'h03);
        check_output("hit_cnt_u0_five", 128'(p_hit_cnt), 128'd5);
        cnt_clr = 1'b1;
        apply_stimulus(32'h0000_0200, 4'b0011, 64'h0000_0000_1111_2222, 16'h2222, 16'h3333, 2'd0, 1'b0);
        cnt_clr = 1'b0;
        check_output("clr_vs_hit", 128'(p_hit_cnt), 128'd0);
        check_output("clr_vs_hit_multi", 128'({p_miss_cnt, p_multi_cnt}), 128'd0);
        check_output("or_clr_vs_hit", 128'({o_hit_cnt, o_miss_cnt, o_multi_cnt}), 128'd0);
        wait_drain();

        $display("[TB] reset mid-stream");
        ready_in = 1'b0;
        apply_stimulus(32'h0000_000D, 4'b0010, 64'h0000_0000_00D0_0000, 16'h00D0, 16'h00D0, 2'd1, 1'b0);
        apply_stimulus(32'h0000_000E, 4'b0100, 64'h0000_0E00_0000_0000, 16'h0E00, 16'h0E00, 2'd2, 1'b0);
        check_output("full_before_reset", 128'(p_ready_out), 128'd0);
        aresetn = 1'b0;
        exp_q.delete();
        #1;
        check_output("midreset_valid", 128'({p_valid_out, o_valid_out}), 128'd0);
        check_output("midreset_ready", 128'({p_ready_out, o_ready_out}), 128'b11);
        check_output("midreset_phv", 128'(p_phv_out), 128'd0);
        @(posedge axis_clk);
        #1;
        aresetn = 1'b1;
        ready_in = 1'b1;
        apply_stimulus(32'h0000_000F, 4'b1111, 64'h1000_0200_0030_0004, 16'h0004, 16'h1234, 2'd0, 1'b0);
        check_output("post_reset_latency_valid", 128'(p_valid_out), 128'd1);
        check_output("post_reset_latency_phv", 128'(p_phv_out), 128'h0F);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
